wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Parametrised Wishbone (pipelined, single-outstanding) bus master driven by the decoded command stream from the UART command decoder. It sits between the command decoder and the Wishbone interconnect. It executes set-address, read, write and special commands over the full address and data width, with optional address auto-increment. Every command returns exactly one response word, including bus-error and timeout reports, and the block emits a reset announcement after every reset.

## Interface
- AW, 30, Wishbone word-address width; must satisfy AW <= DW-2
- DW, 32, Wishbone data width; multiple of 8
- TIMEOUT, 1023, maximum cycles from bus request to ack/err before abort; must be >= 2
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cmd_stb  in  1  command valid; accepted when o_cmd_busy=0
- i_cmd_word  in  DW+2  [DW+1:DW] sub-command, [DW-1:0] payload
- o_cmd_busy  out  1  block cannot accept a command
- o_rsp_stb  out  1  response valid; held until accepted
- o_rsp_word  out  DW+2  response word
- i_rsp_busy  in  1  downstream stall; response accepted in a cycle with o_rsp_stb=1 and i_rsp_busy=0
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone cycle, strobe, write enable
- o_wb_addr  out  AW  word address
- o_wb_data  out  DW  write data
- o_wb_sel  out  DW/8  byte select; constant all ones
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone stall, acknowledge, error
- i_wb_data  in  DW  read data

## Operation
- **Command sub-codes**
  - 00 read.
  - 01 write; payload is the write data.
  - 10 set address: o_wb_addr <= payload[AW-1:0]; auto-increment flag <= payload[DW-2].
  - 11 special: payload[DW-1:DW-3]=0 is a ping. Other special codes are accepted and produce no response.
- **Response words**
  - Read data: {00, i_wb_data}.
  - Write ack: {01, 0}.
  - Address echo: {10, zero-extended new address}.
  - Reset / ping: {11, 3'h0, 0}.
  - Bus error / timeout: {11, 3'h1, 0}.
- **FSM states:** RST_RSP, IDLE, BUS, WAIT_ACK, RESP.
  - RST_RSP is entered from reset and presents the reset word. It goes to IDLE on acceptance.
  - IDLE: an accepted read or write goes to BUS. An accepted address or ping command goes to RESP with the corresponding word. Other special codes stay in IDLE.
  - BUS: cyc=stb=1. When i_wb_stall=0, go to WAIT_ACK with stb=0.
  - WAIT_ACK: cyc=1, stb=0.
  - RESP: o_rsp_stb=1. On acceptance, go to IDLE.
- **Completion:** in BUS or WAIT_ACK, a cycle with i_wb_ack or i_wb_err ends the access.
  - cyc and stb drop on the next edge and the FSM goes to RESP.
  - If ack and err are both high, err has priority.
  - If ack arrives in BUS while stall=1, the access is still complete.
- **Auto-increment:** on ack completion with the flag set, o_wb_addr <= o_wb_addr+1, modulo 2^AW, so 2^AW-1 wraps to 0. No increment on err or timeout.
- **Timeout:** a counter clears on entry to BUS and counts each cycle in BUS or WAIT_ACK. When it reaches TIMEOUT without ack/err, cyc and stb drop and the error word is presented.
- **Write data:** o_wb_we and o_wb_data are loaded at command acceptance and held through the access.
- **Busy:** o_cmd_busy=1 in every state except IDLE.
- **Ignored commands:** a command presented while busy is not consumed. i_cmd_stb is ignored when o_cmd_busy=1.

## Timing
- **Reset values:** all outputs 0 except o_cmd_busy=1 and o_wb_sel=all ones.
  - Auto-increment flag = 0.
  - Reset asserted mid-access drops cyc/stb at that edge; no response is emitted for the aborted command.
- **Reset announcement:** in the first cycle after reset deasserts, o_rsp_stb=1 with the reset word.
- **Read/write access:** command accepted at edge N.
  - cyc=stb=1 from N+1.
  - With stall=0 and ack in cycle N+2, o_rsp_stb=1 at N+3.
  - o_cmd_busy=0 in the cycle after response acceptance.
- **Stall:** each stall cycle extends BUS by one cycle. The response is valid in the cycle after ack.
- **Address / ping commands:** response valid at N+1. No Wishbone activity.
- **Response hold:** o_rsp_word is stable while o_rsp_stb=1 and i_rsp_busy=1.

## Test plan
- Reset released: o_rsp_stb=1, word {11,0}, busy=1. Busy=0 one cycle after acceptance with i_rsp_busy=0.
- Set-address 0x12345 with incr=1, then read; slave acks with 0xDEADBEEF after 2 wait cycles.
  - Expect address echo {10,0x12345}.
  - Expect o_wb_addr=0x12345, we=0 during the access.
  - Expect response {00,0xDEADBEEF}.
  - Expect address 0x12346 afterwards.
- Set address 0x3FFFFFFF with incr=1, write 0xA5A5A5A5 with stall held 3 cycles.
  - Expect stb held 4 cycles, data/we stable.
  - Expect response {01,0}.
  - Expect address wraps to 0.
- Read answered by i_wb_err: expect response {11,3'h1,0}, cyc drops next edge, address unchanged.
- Slave never acks, TIMEOUT=8: cyc drops after 8 cycles in BUS/WAIT_ACK and the error word is returned. A command issued during the access is not consumed.
- Hold i_rsp_busy=1 for 5 cycles after a read ack: o_rsp_stb and word stable. A reset asserted mid-access clears cyc at that edge and is followed by the reset word.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone bus signals of the command-driven bus master.
// The master modport is the bus master's view; the slave modport is the
// environment's view (command decoder, response sink and Wishbone slave).
interface wb_cmd_master_if #(
   parameter int AW = 30,
   parameter int DW = 32
);
   // command stream from the decoder
   logic             i_cmd_stb;
   logic [DW+1:0]    i_cmd_word;
   logic             o_cmd_busy;

   // response stream towards the encoder
   logic             o_rsp_stb;
   logic [DW+1:0]    o_rsp_word;
   logic             i_rsp_busy;

   // Wishbone pipelined master port
   logic             o_wb_cyc;
   logic             o_wb_stb;
   logic             o_wb_we;
   logic [AW-1:0]    o_wb_addr;
   logic [DW-1:0]    o_wb_data;
   logic [DW/8-1:0]  o_wb_sel;
   logic             i_wb_stall;
   logic             i_wb_ack;
   logic             i_wb_err;
   logic [DW-1:0]    i_wb_data;

   modport master (
      input  i_cmd_stb, i_cmd_word,
      output o_cmd_busy,
      output o_rsp_stb, o_rsp_word,
      input  i_rsp_busy,
      output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
   );

   modport slave (
      output i_cmd_stb, i_cmd_word,
      input  o_cmd_busy,
      input  o_rsp_stb, o_rsp_word,
      output i_rsp_busy,
      input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
      output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
   );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined single-outstanding master executing decoded commands.
// Latency: bus access responds the cycle after ack/err; address/ping respond next cycle.
// Backpressure: o_cmd_busy outside IDLE; response held until i_rsp_busy=0.
module wb_cmd_master #(
   parameter int AW      = 30,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              i_clk,
   input  logic              i_reset,
   wb_cmd_master_if.master   bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] SUB_RD   = 2'b00;
   localparam logic [1:0] SUB_WR   = 2'b01;
   localparam logic [1:0] SUB_ADDR = 2'b10;
   localparam logic [1:0] SUB_SPEC = 2'b11;

   // reset announcement and ping share one word; bus error/timeout has its own
   localparam logic [DW+1:0] RST_WORD = {2'b11, {DW{1'b0}}};
   localparam logic [DW+1:0] ERR_WORD = {2'b11, 3'b001, {(DW-3){1'b0}}};

   typedef enum logic [2:0] {
      RST_RSP,
      IDLE,
      BUS,
      WAIT_ACK,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic              incr_q, incr_d;
   logic              we_q, we_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW+1:0]     rsp_q, rsp_d;
   logic [TW-1:0]     tmo_q, tmo_d;

   logic [1:0]        cmd_sub;
   logic [DW-1:0]     cmd_pay;
   logic              rsp_stb;
   logic              rsp_take;
   logic              tmo_hit;

   assign cmd_sub  = bus.i_cmd_word[DW+1:DW];
   assign cmd_pay  = bus.i_cmd_word[DW-1:0];

   // The reset word is withheld while reset is still asserted so a held
   // reset shows all-quiet outputs; it appears in the first free cycle.
   assign rsp_stb  = (state_q == RESP) || ((state_q == RST_RSP) && !i_reset);
   assign rsp_take = rsp_stb && !bus.i_rsp_busy;

   // counter holds the number of bus cycles already spent; the cycle seen
   // with TIMEOUT-1 is the last one the access may occupy
   assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

   // next-state and datapath updates
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      incr_d  = incr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rsp_d   = rsp_q;
      tmo_d   = tmo_q;

      case (state_q)
         RST_RSP: begin
            if (rsp_take) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (bus.i_cmd_stb) begin
               case (cmd_sub)
                  SUB_RD: begin
                     we_d    = 1'b0;
                     tmo_d   = '0;
                     state_d = BUS;
                  end
                  SUB_WR: begin
                     we_d    = 1'b1;
                     wdata_d = cmd_pay;
                     tmo_d   = '0;
                     state_d = BUS;
                  end
                  SUB_ADDR: begin
                     addr_d  = cmd_pay[AW-1:0];
                     incr_d  = cmd_pay[DW-2];
                     rsp_d   = {2'b10, {(DW-AW){1'b0}}, cmd_pay[AW-1:0]};
                     state_d = RESP;
                  end
                  SUB_SPEC: begin
                     // only ping answers; other special codes are swallowed
                     if (cmd_pay[DW-1:DW-3] == 3'b000) begin
                        rsp_d   = RST_WORD;
                        state_d = RESP;
                     end
                  end
                  default: begin
                     state_d = IDLE;
                  end
               endcase
            end
         end

         BUS, WAIT_ACK: begin
            tmo_d = tmo_q + TW'(1);
            if (bus.i_wb_err) begin
               // err wins over a simultaneous ack; address is left alone
               rsp_d   = ERR_WORD;
               state_d = RESP;
            end else if (bus.i_wb_ack) begin
               // an ack while still stalled in BUS also completes the access
               rsp_d   = we_q ? {2'b01, {DW{1'b0}}} : {2'b00, bus.i_wb_data};
               if (incr_q) begin
                  addr_d = addr_q + AW'(1);
               end
               state_d = RESP;
            end else if (tmo_hit) begin
               rsp_d   = ERR_WORD;
               state_d = RESP;
            end else if ((state_q == BUS) && !bus.i_wb_stall) begin
               state_d = WAIT_ACK;
            end
         end

         RESP: begin
            if (rsp_take) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = RST_RSP;
         end
      endcase
   end

   // state and datapath registers; reset aborts any access in flight
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= RST_RSP;
         addr_q  <= '0;
         incr_q  <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rsp_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         incr_q  <= incr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rsp_q   <= rsp_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.o_cmd_busy = (state_q != IDLE);
   assign bus.o_rsp_stb  = rsp_stb;
   assign bus.o_rsp_word = (state_q == RESP) ? rsp_q :
                           rsp_stb           ? RST_WORD : '0;

   assign bus.o_wb_cyc   = (state_q == BUS) || (state_q == WAIT_ACK);
   assign bus.o_wb_stb   = (state_q == BUS);
   assign bus.o_wb_we    = we_q;
   assign bus.o_wb_addr  = addr_q;
   assign bus.o_wb_data  = wdata_q;
   assign bus.o_wb_sel   = '1;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed commands, a scoreboard queue
// of expected response words and a monitor that checks every presented response.
module tb_wb_cmd_master;

   localparam int AW = 30;
   localparam int DW = 32;

   localparam logic [33:0] W_RST = {2'b11, 32'h0000_0000};
   localparam logic [33:0] W_ERR = {2'b11, 32'h2000_0000};
   localparam logic [33:0] W_WRA = {2'b01, 32'h0000_0000};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [DW+1:0] exp_q[$];

   always #5 clk = ~clk;

   wb_cmd_master_if #(.AW(AW), .DW(DW)) bus();

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // response monitor: every presented word must match the scoreboard head
   initial begin
      logic [DW+1:0] dropped;
      forever begin
         @(negedge clk);
         if (!rst && bus.o_rsp_stb) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got %0h expected no response", bus.o_rsp_word);
            end else begin
               chk("rsp_word", 64'(bus.o_rsp_word), 64'(exp_q[0]));
               if (!bus.i_rsp_busy) dropped = exp_q.pop_front();
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (!bus.o_cmd_busy) return;
         step();
      end
      chk("wait_idle_timeout", 64'(bus.o_cmd_busy), 64'd0);
   endtask

   task automatic send_cmd(input logic [1:0] sub, input logic [31:0] pay);
      wait_idle();
      bus.i_cmd_stb  = 1'b1;
      bus.i_cmd_word = {sub, pay};
      step();
      bus.i_cmd_stb  = 1'b0;
   endtask

   // Slave side of one access, entered in the first BUS cycle.
   // mode 0 = ack with rd, 1 = err.
   task automatic do_access(input int stall_n, input int wait_n, input int mode,
                            input logic [31:0] rd, input logic exp_we,
                            input logic [31:0] exp_wd, input logic [29:0] exp_addr);
      for (int i = 0; i <= stall_n; i++) begin
         bus.i_wb_stall = (i < stall_n);
         @(negedge clk);
         chk("stb_held", 64'(bus.o_wb_stb), 64'd1);
         chk("cyc_held", 64'(bus.o_wb_cyc), 64'd1);
         chk("we_during", 64'(bus.o_wb_we), 64'(exp_we));
         chk("addr_during", 64'(bus.o_wb_addr), 64'(exp_addr));
         if (exp_we) chk("wdata_during", 64'(bus.o_wb_data), 64'(exp_wd));
         step();
      end
      bus.i_wb_stall = 1'b0;
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         chk("stb_dropped_wait", 64'(bus.o_wb_stb), 64'd0);
         chk("cyc_wait", 64'(bus.o_wb_cyc), 64'd1);
         step();
      end
      if (mode == 0) begin
         bus.i_wb_ack  = 1'b1;
         bus.i_wb_data = rd;
      end else begin
         bus.i_wb_err  = 1'b1;
      end
      step();
      bus.i_wb_ack  = 1'b0;
      bus.i_wb_err  = 1'b0;
      bus.i_wb_data = '0;
      @(negedge clk);
      chk("cyc_drop", 64'(bus.o_wb_cyc), 64'd0);
      chk("rsp_after_done", 64'(bus.o_rsp_stb), 64'd1);
   endtask

   initial begin
      int n;
      bus.i_cmd_stb  = 1'b0;
      bus.i_cmd_word = '0;
      bus.i_rsp_busy = 1'b0;
      bus.i_wb_stall = 1'b0;
      bus.i_wb_ack   = 1'b0;
      bus.i_wb_err   = 1'b0;
      bus.i_wb_data  = '0;

      // reset state
      rst = 1'b1;
      repeat (3) step();
      chk("rst_rsp_stb", 64'(bus.o_rsp_stb), 64'd0);
      chk("rst_busy", 64'(bus.o_cmd_busy), 64'd1);
      chk("rst_cyc", 64'(bus.o_wb_cyc), 64'd0);
      chk("rst_sel", 64'(bus.o_wb_sel), 64'hF);
      chk("rst_addr", 64'(bus.o_wb_addr), 64'd0);
      exp_q.push_back(W_RST);
      rst = 1'b0;
      @(negedge clk);
      chk("announce_stb", 64'(bus.o_rsp_stb), 64'd1);
      chk("announce_busy", 64'(bus.o_cmd_busy), 64'd1);
      step();
      chk("busy_after_announce", 64'(bus.o_cmd_busy), 64'd0);

      // set address 0x12345 with increment, then read with 2 wait cycles
      exp_q.push_back({2'b10, 32'h0001_2345});
      send_cmd(2'b10, 32'h4001_2345);
      @(negedge clk);
      chk("addr_rsp_next_cycle", 64'(bus.o_rsp_stb), 64'd1);
      chk("addr_no_cyc", 64'(bus.o_wb_cyc), 64'd0);
      exp_q.push_back({2'b00, 32'hDEAD_BEEF});
      send_cmd(2'b00, 32'h0);
      do_access(0, 2, 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 30'h12345);
      wait_idle();
      chk("addr_incr", 64'(bus.o_wb_addr), 64'h12346);

      // wrap: address 0x3FFFFFFF, write with 3 stall cycles
      exp_q.push_back({2'b10, 32'h3FFF_FFFF});
      send_cmd(2'b10, 32'h7FFF_FFFF);
      exp_q.push_back(W_WRA);
      send_cmd(2'b01, 32'hA5A5_A5A5);
      do_access(3, 1, 0, 32'h0, 1'b1, 32'hA5A5_A5A5, 30'h3FFF_FFFF);
      wait_idle();
      chk("addr_wrap", 64'(bus.o_wb_addr), 64'd0);

      // read answered by err: no increment
      exp_q.push_back(W_ERR);
      send_cmd(2'b00, 32'h0);
      do_access(0, 1, 1, 32'h0, 1'b0, 32'h0, 30'h0);
      wait_idle();
      chk("addr_after_err", 64'(bus.o_wb_addr), 64'd0);

      // slave never answers; a set-address offered meanwhile must be ignored
      exp_q.push_back(W_ERR);
      send_cmd(2'b00, 32'h0);
      bus.i_cmd_word = {2'b10, 32'h0000_0555};
      bus.i_cmd_stb  = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.o_wb_cyc) break;
         n++;
         if (n <= 3) chk("busy_in_access", 64'(bus.o_cmd_busy), 64'd1);
         step();
         bus.i_cmd_stb = (n < 3);
      end
      bus.i_cmd_stb = 1'b0;
      chk("timeout_cycles", 64'(n), 64'd8);
      wait_idle();
      chk("addr_after_timeout", 64'(bus.o_wb_addr), 64'd0);

      // response held 5 cycles under i_rsp_busy
      exp_q.push_back({2'b00, 32'h0BAD_CAFE});
      send_cmd(2'b00, 32'h0);
      bus.i_rsp_busy = 1'b1;
      do_access(0, 0, 0, 32'h0BAD_CAFE, 1'b0, 32'h0, 30'h0);
      for (int i = 0; i < 5; i++) begin
         chk("hold_stb", 64'(bus.o_rsp_stb), 64'd1);
         if (i < 4) @(negedge clk);
      end
      step();
      bus.i_rsp_busy = 1'b0;
      wait_idle();
      chk("addr_after_hold", 64'(bus.o_wb_addr), 64'd1);

      // ping answers with the reset word; other special codes are silent
      exp_q.push_back(W_RST);
      send_cmd(2'b11, 32'h0);
      wait_idle();
      send_cmd(2'b11, 32'h2000_0000);
      @(negedge clk);
      chk("special_silent_busy", 64'(bus.o_cmd_busy), 64'd0);

      // reset during an access: cyc drops at that edge, reset word follows
      send_cmd(2'b00, 32'h0);
      step();
      rst = 1'b1;
      step();
      chk("reset_drops_cyc", 64'(bus.o_wb_cyc), 64'd0);
      chk("reset_rsp_quiet", 64'(bus.o_rsp_stb), 64'd0);
      exp_q.push_back(W_RST);
      rst = 1'b0;
      @(negedge clk);
      chk("reannounce_stb", 64'(bus.o_rsp_stb), 64'd1);
      wait_idle();
      chk("addr_reset", 64'(bus.o_wb_addr), 64'd0);

      // increment flag cleared by reset
      exp_q.push_back({2'b00, 32'h1234_5678});
      send_cmd(2'b00, 32'h0);
      do_access(0, 0, 0, 32'h1234_5678, 1'b0, 32'h0, 30'h0);
      wait_idle();
      chk("no_incr_after_reset", 64'(bus.o_wb_addr), 64'd0);

      repeat (5) step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
